// File: rtl/caliptra_prim_lc_stage_seq.sv
// rtl/caliptra_prim_lc_stage_seq.sv - life-cycle enable qualifier and staged, ack-gated ramp sequencer
// Fans one synchronized lc_tx_t enable out to NumStages consumers in order.

module caliptra_prim_sec_anchor_buf #(
    parameter int Width = 1
) (
    input  logic [Width-1:0] i_in,
    output logic [Width-1:0] o_out
);
    assign o_out = i_in;
endmodule

module caliptra_prim_lc_stage_seq #(
    parameter int NumStages    = 3,
    parameter int StableCycles = 4,
    parameter int AckTimeout   = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [3:0]             lc_en_i,
    input  logic [NumStages-1:0]   stage_ack_i,
    output logic [4*NumStages-1:0] stage_en_o,
    output logic                   all_on_o,
    output logic                   busy_o,
    output logic                   err_invalid_o,
    output logic                   err_timeout_o
);

    localparam logic [3:0] LcOn  = 4'b0101;
    localparam logic [3:0] LcOff = 4'b1010;

    localparam int CntMaxVal = (StableCycles > AckTimeout) ? StableCycles : AckTimeout;
    localparam int CntW      = $clog2(CntMaxVal + 1);
    localparam int IdxW      = (NumStages > 1) ? $clog2(NumStages) : 1;

    localparam logic [CntW-1:0] StableCnt  = CntW'(StableCycles);
    localparam logic [CntW-1:0] TimeoutCnt = CntW'(AckTimeout - 1);
    localparam logic [CntW-1:0] CntSat     = {CntW{1'b1}};
    localparam logic [IdxW-1:0] LastIdx    = IdxW'(NumStages - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_QUAL,
        ST_RAMP,
        ST_ON,
        ST_ERROR
    } state_e;

    state_e                      r_state;
    state_e                      w_state_nxt;
    logic [CntW-1:0]             r_cnt;
    logic [CntW-1:0]             w_cnt_nxt;
    logic [CntW-1:0]             w_cnt_inc;
    logic [IdxW-1:0]             r_idx;
    logic [IdxW-1:0]             w_idx_nxt;
    logic [IdxW-1:0]             w_idx_adv;
    logic [NumStages-1:0][3:0]   r_stage_en;
    logic [NumStages-1:0]        w_stage_on;
    logic [NumStages-1:0]        w_stage_on_nxt;
    logic                        r_err_inv;
    logic                        w_err_inv_nxt;
    logic                        r_err_to;
    logic                        w_err_to_nxt;
    logic                        w_lc_off;
    logic                        w_lc_inv;
    logic                        w_ack_cur;

    assign w_lc_off  = (lc_en_i == LcOff);
    assign w_lc_inv  = (lc_en_i != LcOn) && !w_lc_off;
    assign w_ack_cur = stage_ack_i[r_idx];
    assign w_cnt_inc = (r_cnt == CntSat) ? r_cnt : r_cnt + CntW'(1);
    assign w_idx_adv = r_idx + IdxW'(1);

    always_comb begin
        w_stage_on = '0;
        for (int k = 0; k < NumStages; k++) begin
            w_stage_on[k] = (r_stage_en[k] == LcOn);
        end
    end

    // Priority: invalid encoding, then Off, then ack/timeout, then counting.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_idx_nxt      = r_idx;
        w_stage_on_nxt = w_stage_on;
        w_err_inv_nxt  = r_err_inv;
        w_err_to_nxt   = r_err_to;
        if (r_state == ST_ERROR) begin
            w_stage_on_nxt = '0;
            if (w_lc_inv) begin
                w_err_inv_nxt = 1'b1;
            end
        end else if (w_lc_inv) begin
            w_state_nxt    = ST_ERROR;
            w_stage_on_nxt = '0;
            w_err_inv_nxt  = 1'b1;
            w_cnt_nxt      = '0;
            w_idx_nxt      = '0;
        end else if (w_lc_off) begin
            w_state_nxt    = ST_IDLE;
            w_stage_on_nxt = '0;
            w_cnt_nxt      = '0;
            w_idx_nxt      = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_QUAL;
                    w_cnt_nxt   = CntW'(1);
                end
                ST_QUAL: begin
                    if (r_cnt == StableCnt) begin
                        w_state_nxt       = ST_RAMP;
                        w_idx_nxt         = '0;
                        w_cnt_nxt         = '0;
                        w_stage_on_nxt    = '0;
                        w_stage_on_nxt[0] = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                ST_RAMP: begin
                    // An ack arriving on the timeout edge still advances the ramp.
                    if (w_ack_cur) begin
                        w_cnt_nxt = '0;
                        if (r_idx == LastIdx) begin
                            w_state_nxt = ST_ON;
                        end else begin
                            w_idx_nxt                 = w_idx_adv;
                            w_stage_on_nxt[w_idx_adv] = 1'b1;
                        end
                    end else if (r_cnt == TimeoutCnt) begin
                        w_state_nxt    = ST_ERROR;
                        w_stage_on_nxt = '0;
                        w_err_to_nxt   = 1'b1;
                        w_cnt_nxt      = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                ST_ON: begin
                    w_state_nxt = ST_ON;
                end
                default: begin
                    w_state_nxt    = ST_ERROR;
                    w_stage_on_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_err_inv <= 1'b0;
            r_err_to  <= 1'b0;
            for (int k = 0; k < NumStages; k++) begin
                r_stage_en[k] <= LcOff;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_err_inv <= w_err_inv_nxt;
            r_err_to  <= w_err_to_nxt;
            for (int k = 0; k < NumStages; k++) begin
                r_stage_en[k] <= w_stage_on_nxt[k] ? LcOn : LcOff;
            end
        end
    end

    // Anchor buffers keep each multi-bit enable from being optimised into a single net.
    for (genvar k = 0; k < NumStages; k++) begin : g_stage
        caliptra_prim_sec_anchor_buf #(
            .Width (4)
        ) u_anchor (
            .i_in  (r_stage_en[k]),
            .o_out (stage_en_o[4*k +: 4])
        );

        a_stage_enc: assert property (@(posedge clk_i) disable iff (rst_i)
            (stage_en_o[4*k +: 4] == LcOn) || (stage_en_o[4*k +: 4] == LcOff));

        if (k > 0) begin : g_order
            a_stage_order: assert property (@(posedge clk_i) disable iff (rst_i)
                (stage_en_o[4*k +: 4] == LcOn) |-> (stage_en_o[4*(k-1) +: 4] == LcOn));
        end
    end

    assign all_on_o      = (r_state == ST_ON);
    assign busy_o        = (r_state == ST_QUAL) || (r_state == ST_RAMP);
    assign err_invalid_o = r_err_inv;
    assign err_timeout_o = r_err_to;

    a_known: assert property (@(posedge clk_i) disable iff (rst_i)
        !$isunknown({stage_en_o, all_on_o, busy_o, err_invalid_o, err_timeout_o}));

    a_params_init: assert property (@(posedge clk_i)
        (NumStages >= 1) && (StableCycles >= 1) && (AckTimeout >= 2));

endmodule

// File: tb/tb_caliptra_prim_lc_stage_seq.sv
// tb/tb_caliptra_prim_lc_stage_seq.sv - scoreboard bench for the lc stage sequencer
// Driver queues per-edge expectations; a negedge monitor pops and compares.

module tb_caliptra_prim_lc_stage_seq;

    localparam int NS = 3;
    localparam logic [3:0] ON  = 4'b0101;
    localparam logic [3:0] OFF = 4'b1010;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [3:0]    lc_en = 4'b1010;
    logic [NS-1:0] ack = '0;
    logic [4*NS-1:0] stage_en_o;
    logic          all_on_o;
    logic          busy_o;
    logic          err_invalid_o;
    logic          err_timeout_o;

    typedef struct {
        string           tag;
        logic [4*NS-1:0] en;
        logic            all_on;
        logic            busy;
        logic            einv;
        logic            eto;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    caliptra_prim_lc_stage_seq #(
        .NumStages    (NS),
        .StableCycles (4),
        .AckTimeout   (16)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .lc_en_i       (lc_en),
        .stage_ack_i   (ack),
        .stage_en_o    (stage_en_o),
        .all_on_o      (all_on_o),
        .busy_o        (busy_o),
        .err_invalid_o (err_invalid_o),
        .err_timeout_o (err_timeout_o)
    );

    function automatic logic [4*NS-1:0] enc(input logic [NS-1:0] on);
        logic [4*NS-1:0] r;
        for (int k = 0; k < NS; k++) begin
            r[4*k +: 4] = on[k] ? ON : OFF;
        end
        return r;
    endfunction

    function automatic exp_t mk(input string tag, input logic [NS-1:0] on, input logic all,
                                input logic busy, input logic einv, input logic eto);
        exp_t e;
        e.tag    = tag;
        e.en     = enc(on);
        e.all_on = all;
        e.busy   = busy;
        e.einv   = einv;
        e.eto    = eto;
        return e;
    endfunction

    // Expected values describe the outputs after the edge this step drives into.
    task automatic step(input logic [3:0] lc, input logic [NS-1:0] a, input logic [NS-1:0] on,
                        input logic all, input logic busy, input logic einv, input logic eto,
                        input string tag);
        lc_en = lc;
        ack   = a;
        sb.push_back(mk(tag, on, all, busy, einv, eto));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #1;
        lc_en = OFF;
        ack   = '0;
        rst_i = 1'b1;
        sb.push_back(mk(tag, '0, 1'b0, 1'b0, 1'b0, 1'b0));
        #1;
        n_checks++;
        if ({stage_en_o, all_on_o, busy_o, err_invalid_o, err_timeout_o} !== {enc('0), 4'b0000}) begin
            n_errors++;
            $display("FAIL %s_async got en=%h all_on=%b busy=%b inv=%b to=%b want en=%h flags=0",
                     tag, stage_en_o, all_on_o, busy_o, err_invalid_o, err_timeout_o, enc('0));
        end
        @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_checks++;
            if ({stage_en_o, all_on_o, busy_o, err_invalid_o, err_timeout_o} !==
                {mon_e.en, mon_e.all_on, mon_e.busy, mon_e.einv, mon_e.eto}) begin
                n_errors++;
                $display("FAIL %s got en=%h all_on=%b busy=%b inv=%b to=%b want en=%h all_on=%b busy=%b inv=%b to=%b",
                         mon_e.tag, stage_en_o, all_on_o, busy_o, err_invalid_o, err_timeout_o,
                         mon_e.en, mon_e.all_on, mon_e.busy, mon_e.einv, mon_e.eto);
            end
        end
    end

    initial begin
        do_reset("reset");

        // Straight ramp with all acks high.
        for (int i = 0; i < 4; i++) step(ON, 3'b111, 3'b000, 0, 1, 0, 0, "t1_qual");
        step(ON, 3'b111, 3'b001, 0, 1, 0, 0, "t1_s0");
        step(ON, 3'b111, 3'b011, 0, 1, 0, 0, "t1_s1");
        step(ON, 3'b111, 3'b111, 0, 1, 0, 0, "t1_s2");
        step(ON, 3'b111, 3'b111, 1, 0, 0, 0, "t1_on");
        step(ON, 3'b111, 3'b111, 1, 0, 0, 0, "t1_hold");
        step(OFF, 3'b111, 3'b000, 0, 0, 0, 0, "t1_off");

        // Qualification aborted short of and exactly at StableCycles.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) step(ON, 3'b111, 3'b000, 0, 1, 0, 0, "t2_qual");
            step(OFF, 3'b111, 3'b000, 0, 0, 0, 0, "t2_off");
        end
        for (int i = 0; i < 4; i++) step(ON, 3'b111, 3'b000, 0, 1, 0, 0, "t2_qual4");
        step(OFF, 3'b111, 3'b000, 0, 0, 0, 0, "t2_off4");
        step(OFF, 3'b111, 3'b000, 0, 0, 0, 0, "t2_idle");

        // Off with the pending ack on the same edge, then full requalification.
        for (int i = 0; i < 4; i++) step(ON, 3'b001, 3'b000, 0, 1, 0, 0, "t5_qual");
        step(ON, 3'b001, 3'b001, 0, 1, 0, 0, "t5_s0");
        step(ON, 3'b001, 3'b011, 0, 1, 0, 0, "t5_s1");
        for (int i = 0; i < 2; i++) step(ON, 3'b101, 3'b011, 0, 1, 0, 0, "t5_other_ack");
        step(OFF, 3'b010, 3'b000, 0, 0, 0, 0, "t5_off_ack");
        for (int i = 0; i < 4; i++) step(ON, 3'b000, 3'b000, 0, 1, 0, 0, "t5_requal");
        step(ON, 3'b000, 3'b001, 0, 1, 0, 0, "t5_re_s0");
        step(ON, 3'b001, 3'b011, 0, 1, 0, 0, "t5_re_s1");
        step(ON, 3'b010, 3'b111, 0, 1, 0, 0, "t5_re_s2");
        step(ON, 3'b100, 3'b111, 1, 0, 0, 0, "t5_on");
        for (int i = 0; i < 2; i++) step(ON, 3'b000, 3'b111, 1, 0, 0, 0, "t5_ack_drop");

        // Invalid encoding while ON is absorbing.
        step(4'b0111, 3'b000, 3'b000, 0, 0, 1, 0, "t4_inv");
        for (int i = 0; i < 3; i++) step(ON, 3'b111, 3'b000, 0, 0, 1, 0, "t4_err_hold");
        step(OFF, 3'b111, 3'b000, 0, 0, 1, 0, "t4_err_off");
        do_reset("t4_reset");

        // Ack timeout on stage 1.
        for (int i = 0; i < 4; i++) step(ON, 3'b001, 3'b000, 0, 1, 0, 0, "t3_qual");
        step(ON, 3'b001, 3'b001, 0, 1, 0, 0, "t3_s0");
        step(ON, 3'b001, 3'b011, 0, 1, 0, 0, "t3_s1");
        for (int i = 0; i < 15; i++) step(ON, 3'b101, 3'b011, 0, 1, 0, 0, "t3_wait");
        step(ON, 3'b101, 3'b000, 0, 0, 0, 1, "t3_timeout");
        for (int i = 0; i < 2; i++) step(ON, 3'b111, 3'b000, 0, 0, 0, 1, "t3_err_hold");
        step(4'b0000, 3'b111, 3'b000, 0, 0, 1, 1, "t3_err_inv");
        do_reset("t3_reset");

        // Ack arriving on the timeout edge wins.
        for (int i = 0; i < 4; i++) step(ON, 3'b001, 3'b000, 0, 1, 0, 0, "tw_qual");
        step(ON, 3'b001, 3'b001, 0, 1, 0, 0, "tw_s0");
        step(ON, 3'b001, 3'b011, 0, 1, 0, 0, "tw_s1");
        for (int i = 0; i < 15; i++) step(ON, 3'b000, 3'b011, 0, 1, 0, 0, "tw_wait");
        step(ON, 3'b010, 3'b111, 0, 1, 0, 0, "tw_ack_wins");
        step(ON, 3'b100, 3'b111, 1, 0, 0, 0, "tw_on");

        // Asynchronous reset in the middle of a ramp.
        step(OFF, 3'b000, 3'b000, 0, 0, 0, 0, "t6_off");
        for (int i = 0; i < 4; i++) step(ON, 3'b000, 3'b000, 0, 1, 0, 0, "t6_qual");
        step(ON, 3'b000, 3'b001, 0, 1, 0, 0, "t6_s0");
        do_reset("t6_midramp");
        step(ON, 3'b000, 3'b000, 0, 1, 0, 0, "t6_requal");
        step(OFF, 3'b000, 3'b000, 0, 0, 0, 0, "t6_off2");

        @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
